// File: rtl/alu_iterative.sv
// Registered LEGv8 execute-stage ALU: single-cycle logic/add/sub plus iterative MUL/UDIV/SDIV.
// One bit per cycle for MUL/DIV, start/done handshake, full NZCV flags.
module alu_iterative #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_UDIV = 4'b1001;
  localparam logic [3:0] OP_SDIV = 4'b1010;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // product accumulator / partial remainder
  logic [WIDTH-1:0]   x_q, x_d;       // multiplicand / divisor
  logic [WIDTH-1:0]   y_q, y_d;       // multiplier / dividend shifting into quotient
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     add_w, sub_w, rem_sh;
  logic [WIDTH-1:0]   a_abs, b_abs, prod_w, rem_dif;
  logic               div_ge;

  logic               wr_res, nz_en, c_new, v_new;
  logic [WIDTH-1:0]   res_new;

  assign add_w   = {1'b0, a} + {1'b0, b};
  assign sub_w   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign a_abs   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_abs   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign prod_w  = y_q[0] ? (acc_q + x_q) : acc_q;
  assign rem_sh  = {acc_q, y_q[WIDTH-1]};
  assign div_ge  = (rem_sh >= {1'b0, x_q});
  // The true difference is below the divisor, so the low WIDTH bits suffice.
  assign rem_dif = rem_sh[WIDTH-1:0] - x_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    neg_d    = neg_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    wr_res   = 1'b0;
    nz_en    = 1'b1;
    c_new    = 1'b0;
    v_new    = 1'b0;
    res_new  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (alu_control)
            OP_AND:  begin wr_res = 1'b1; res_new = a & b; end
            OP_OR:   begin wr_res = 1'b1; res_new = a | b; end
            OP_XOR:  begin wr_res = 1'b1; res_new = a ^ b; end
            OP_NOR:  begin wr_res = 1'b1; res_new = ~(a | b); end
            OP_PASS: begin wr_res = 1'b1; res_new = b; end
            OP_ADD: begin
              wr_res  = 1'b1;
              res_new = add_w[WIDTH-1:0];
              c_new   = add_w[WIDTH];
              v_new   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              wr_res  = 1'b1;
              res_new = sub_w[WIDTH-1:0];
              c_new   = sub_w[WIDTH];
              v_new   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
              state_d = S_MUL;
              cnt_d   = '0;
              acc_d   = '0;
              x_d     = a;
              y_d     = b;
              neg_d   = 1'b0;
            end
            OP_UDIV: begin
              state_d = S_DIV;
              cnt_d   = '0;
              acc_d   = '0;
              x_d     = b;
              y_d     = a;
              neg_d   = 1'b0;
            end
            OP_SDIV: begin
              state_d = S_DIV;
              cnt_d   = '0;
              acc_d   = '0;
              x_d     = b_abs;
              y_d     = a_abs;
              neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            end
            default: begin
              wr_res = 1'b1;
              nz_en  = 1'b0;
            end
          endcase
        end
      end

      S_MUL: begin
        acc_d = prod_w;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_IDLE;
          wr_res  = 1'b1;
          res_new = prod_w;
        end
      end

      S_DIV: begin
        acc_d = div_ge ? rem_dif : rem_sh[WIDTH-1:0];
        y_d   = {y_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end

      S_FIX: begin
        // A zero divisor leaves an all-ones quotient; force the defined zero result.
        state_d = S_IDLE;
        wr_res  = 1'b1;
        if (x_q == '0)  res_new = '0;
        else if (neg_q) res_new = ~y_q + WIDTH'(1);
        else            res_new = y_q;
      end

      default: state_d = S_IDLE;
    endcase

    if (wr_res) begin
      result_d = res_new;
      n_d      = nz_en & res_new[WIDTH-1];
      z_d      = nz_en & (res_new == '0);
      c_d      = c_new;
      v_d      = v_new;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign negative = n_q;
  assign zero     = z_q;
  assign carry    = c_q;
  assign overflow = v_q;

endmodule
